// File: rtl/rx78_pkg.sv
// Shared definitions for the rx78 cartridge download path.
package rx78_pkg;

    localparam int unsigned CART_AW_DEF   = 15;
    localparam logic [7:0]  CART_PAD_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } cart_state_t;

endpackage

// File: rtl/rx78_cart_loader_if.sv
// HPS download bus plus cartridge ROM write port of the rx78 cart loader.
// slave: the loader side; master: the HPS / ROM side.
interface rx78_cart_loader_if #(
    parameter int unsigned CART_AW = 15
);
    logic               ioctl_download;
    logic [7:0]         ioctl_index;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;

    logic [CART_AW-1:0] cart_addr;
    logic [7:0]         cart_data;
    logic               cart_we;
    logic [CART_AW:0]   cart_size;
    logic               cart_valid;
    logic               overflow;
    logic               busy;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output cart_addr, cart_data, cart_we, cart_size, cart_valid, overflow, busy
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cart_addr, cart_data, cart_we, cart_size, cart_valid, overflow, busy
    );
endinterface

// File: rtl/rx78_edge_det.sv
// Registered rise/fall detector: edges are reported in the cycle the input
// differs from its registered copy.
module rx78_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_prev;

    // Registered copy of the input.
    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;
endmodule

// File: rtl/rx78_cart_loader.sv
// Cartridge download stage: HPS bytes -> registered cartridge ROM write port,
// image size / overflow tracking and busy flag for the core reset.
// Optional feature macro: CART_RX78_PAD_EN (pad unused ROM tail with 0xFF).
module rx78_cart_loader
    import rx78_pkg::*;
#(
    parameter int unsigned CART_AW    = CART_AW_DEF,
    parameter logic [7:0]  CART_INDEX = 8'd1
) (
    input logic               clk,
    input logic               reset,
    rx78_cart_loader_if.slave bus
);
    localparam logic [CART_AW:0] FULL = {1'b1, {CART_AW{1'b0}}};

    cart_state_t        r_state, w_state_nxt;
    logic [CART_AW-1:0] r_addr, w_addr;
    logic [7:0]         r_data, w_data;
    logic               r_we, w_we;
    logic [CART_AW:0]   r_size, w_size_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_valid, w_valid_nxt;

    logic               w_rise, w_fall;
    logic               w_sel, w_start, w_in_range;
    logic [CART_AW:0]   w_byte_end;

    rx78_edge_det u_dl_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.ioctl_download),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_sel      = (bus.ioctl_index == CART_INDEX);
    assign w_start    = bus.ioctl_download & w_sel;
    assign w_in_range = ~|bus.ioctl_addr[24:CART_AW];
    assign w_byte_end = {1'b0, bus.ioctl_addr[CART_AW-1:0]} + (CART_AW+1)'(1);

`ifdef CART_RX78_PAD_EN
    logic [CART_AW-1:0] r_pad_ptr, w_pad_ptr_nxt;
    logic               w_start_edge;
    assign w_start_edge = w_rise & w_sel;
`else
    logic w_unused_rise;
    assign w_unused_rise = w_rise;
`endif

    // Next state, write port and counter updates.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = r_addr;
        w_data      = r_data;
        w_size_nxt  = r_size;
        w_ovf_nxt   = r_ovf;
`ifdef CART_RX78_PAD_EN
        w_pad_ptr_nxt = r_pad_ptr;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_nxt = LOAD;
                    w_size_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            LOAD: begin
                // A byte coincident with the download falling is still taken.
                if (bus.ioctl_wr) begin
                    if (w_in_range) begin
                        w_we   = 1'b1;
                        w_addr = bus.ioctl_addr[CART_AW-1:0];
                        w_data = bus.ioctl_dout;
                        if (w_byte_end > r_size) w_size_nxt = w_byte_end;
                    end else begin
                        w_ovf_nxt  = 1'b1;
                        w_size_nxt = FULL;
                    end
                end
                if (w_fall) begin
`ifdef CART_RX78_PAD_EN
                    // A full image skips PAD so cart_valid timing matches the no-pad case.
                    if (w_size_nxt == FULL) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt   = PAD;
                        w_pad_ptr_nxt = w_size_nxt[CART_AW-1:0];
                    end
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef CART_RX78_PAD_EN
            PAD: begin
                if (w_start_edge) begin
                    w_state_nxt = LOAD;
                    w_size_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    w_we          = 1'b1;
                    w_addr        = r_pad_ptr;
                    w_data        = CART_PAD_BYTE;
                    w_pad_ptr_nxt = r_pad_ptr + CART_AW'(1);
                    if (&r_pad_ptr) w_state_nxt = DONE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_valid_nxt = (r_state == DONE) & ~w_start;

    // State, registered write port and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_we    <= w_we;
            r_size  <= w_size_nxt;
            r_ovf   <= w_ovf_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef CART_RX78_PAD_EN
    // Pad pointer.
    always_ff @(posedge clk) begin
        if (reset) r_pad_ptr <= '0;
        else       r_pad_ptr <= w_pad_ptr_nxt;
    end
`endif

    assign bus.cart_addr  = r_addr;
    assign bus.cart_data  = r_data;
    assign bus.cart_we    = r_we;
    assign bus.cart_size  = r_size;
    assign bus.cart_valid = r_valid;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = (r_state == LOAD) || (r_state == PAD);
endmodule

// File: doc/rx78_cart_loader.md
# rx78_cart_loader

Cartridge download stage sitting between the HPS download interface and the rx78 machine core. Accepts cartridge bytes streamed by the HPS, writes them into the core's cartridge ROM through a registered write port, tracks image size, and optionally pads the unused tail of the ROM with 0xFF. Provides a busy flag that holds the core in reset while the cartridge image is being loaded or padded.

## Interface
- CART_AW, 15: cartridge ROM address width (32 KiB).
- CART_INDEX, 8'd1: ioctl_index value that selects a cartridge download.
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download target selector.
- ioctl_wr  in  1  one-cycle strobe; ioctl_addr/ioctl_dout valid.
- ioctl_addr  in  25  byte address within the image.
- ioctl_dout  in  8  byte data.
- cart_addr  out  CART_AW  ROM write address.
- cart_data  out  8  ROM write data.
- cart_we  out  1  ROM write enable, one cycle per byte.
- cart_size  out  CART_AW+1  bytes accepted in the last download, saturating at 2^CART_AW.
- cart_valid  out  1  a complete image is present.
- overflow  out  1  the last download contained bytes at or beyond 2^CART_AW.
- busy  out  1  load or pad in progress; OR into the core reset.

## Operation
- States: IDLE, LOAD, PAD, DONE.
- IDLE: on ioctl_download=1 with ioctl_index==CART_INDEX go to LOAD; clear cart_size, overflow, and cart_valid.
- LOAD: each ioctl_wr with ioctl_addr < 2^CART_AW produces a write with cart_addr=ioctl_addr[CART_AW-1:0] and cart_data=ioctl_dout. cart_size = max(cart_size, ioctl_addr+1).
- LOAD: an ioctl_wr with ioctl_addr >= 2^CART_AW produces no write and sets overflow. cart_size saturates at 2^CART_AW.
- LOAD: on ioctl_download falling, go to PAD if CART_RX78_PAD_EN is defined, otherwise go to DONE.
- PAD: pad pointer starts at cart_size. Each cycle issue one write of 0xFF and increment the pointer. After writing address 2^CART_AW-1, go to DONE. If cart_size is already 2^CART_AW, go straight to DONE with zero writes.
- DONE: cart_valid=1. A new qualifying download re-enters LOAD from DONE, as from IDLE.
- Downloads with any other index are ignored in every state.
- busy = (state==LOAD) or (state==PAD).
- A qualifying ioctl_download rising during PAD aborts the pad and enters LOAD on the next cycle with counters cleared.
- ioctl_wr in the same cycle as ioctl_download falls is accepted as the final byte before the transition.

## Timing
- Reset values: cart_addr=0, cart_data=0, cart_we=0, cart_size=0, cart_valid=0, overflow=0, busy=0, state=IDLE.
- reset takes priority over all inputs and aborts LOAD/PAD immediately. No write is issued in the reset cycle.
- Latency: ioctl_wr in cycle N gives cart_we=1 in cycle N+1, with cart_addr/cart_data registered.
- The ioctl_download falling edge is detected on a registered copy. The first PAD write appears 2 cycles after the falling edge (1 cycle of edge detect plus the LOAD→PAD transition).
- PAD sustains one write per cycle. Pad duration is 2^CART_AW − cart_size cycles.
- cart_valid rises in the cycle after the last write.
- Back-to-back ioctl_wr on consecutive cycles is supported with no drops.

## Configuration
- CART_RX78_PAD_EN defined: PAD state exists and unused ROM bytes read 0xFF after load. This gives deterministic contents for images shorter than 32 KiB.
- CART_RX78_PAD_EN undefined: LOAD goes directly to DONE, and stale bytes from earlier images remain in the ROM. The PAD logic and pointer are not synthesized.

## Structure
- Shared package rx78_pkg holds:
  - typedef cart_state_t {IDLE, LOAD, PAD, DONE}
  - localparam CART_PAD_BYTE = 8'hFF
  - CART_AW default
- One sub-module is natural: rx78_edge_det (registered rise/fall detector), used for ioctl_download.
- Everything else is flat.

## Test plan
- Load 8192 bytes (addr 0..8191, data=addr[7:0]) with index 1 → 8192 writes, each with cart_we one cycle after its ioctl_wr. cart_size=8192, overflow=0. With PAD_EN: 24576 writes of 0xFF at 8192..32767, then cart_valid=1.
- Load 40000 bytes → writes only for 0..32767, cart_size=32768, overflow=1. No pad writes. cart_valid=1 two cycles after ioctl_download falls.
- Download with index 0 while in DONE → no cart_we, cart_valid stays 1, busy stays 0.
- Assert reset mid-LOAD at byte 100 → next cycle all outputs at reset values. A subsequent 16-byte load gives cart_size=16.
- Start a new index-1 download during PAD at pointer 20000 → pad stops, cart_size restarts at 0, busy stays 1 throughout.
- Back-to-back ioctl_wr on 4 consecutive cycles, with the last coincident with ioctl_download falling → all 4 bytes written, cart_size=4.
